// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data-memory wait, taken branch/jump squash,
// load-use interlock, fetch-miss bubble and sticky halt, with stall/flush counters.
package hazard_ctrl_pkg;
  typedef logic [4:0] regbits_t;
  typedef enum logic [2:0] {
    PCSRC_NEXT = 3'd0,
    PCSRC_BEQ  = 3'd1,
    PCSRC_BNE  = 3'd2,
    PCSRC_JAL  = 3'd3,
    PCSRC_REG  = 3'd4
  } pcsrc_t;
endpackage

module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  regbits_t    id_rs,
  input  regbits_t    id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_dREN,
  input  regbits_t    ex_regtbw,
  input  logic        mem_dREN,
  input  logic        mem_dWEN,
  input  pcsrc_t      mem_pcsrc,
  input  logic        mem_zero,
  input  logic        wb_halt,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        pc_redirect,
  output logic        halt,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        halt_r;
  logic [31:0] stall_cycles_r;
  logic [31:0] flush_count_r;

  logic        taken_s;
  logic        dstall_s;
  logic        loaduse_s;
  logic        stall_inc_s;
  logic        flush_inc_s;
  logic        pc_en_s;
  logic        if_id_en_s;
  logic        id_ex_en_s;
  logic        ex_mem_en_s;
  logic        mem_wb_en_s;
  logic        if_id_flush_s;
  logic        id_ex_flush_s;
  logic        ex_mem_flush_s;
  logic        pc_redirect_s;

  // Hazard detection terms
  always_comb begin
    taken_s   = (mem_pcsrc == PCSRC_REG) | (mem_pcsrc == PCSRC_JAL) |
                ((mem_pcsrc == PCSRC_BEQ) & mem_zero) |
                ((mem_pcsrc == PCSRC_BNE) & ~mem_zero);
    dstall_s  = (mem_dREN | mem_dWEN) & ~dhit;
    loaduse_s = ex_dREN & (ex_regtbw != 5'd0) &
                ((id_uses_rs & (id_rs == ex_regtbw)) |
                 (id_uses_rt & (id_rt == ex_regtbw)));
  end

  // Next-state and enable/flush decode; RUN and DWAIT share one priority chain
  always_comb begin
    state_nxt_s    = state_r;
    pc_en_s        = 1'b0;
    if_id_en_s     = 1'b0;
    id_ex_en_s     = 1'b0;
    ex_mem_en_s    = 1'b0;
    mem_wb_en_s    = 1'b0;
    if_id_flush_s  = 1'b0;
    id_ex_flush_s  = 1'b0;
    ex_mem_flush_s = 1'b0;
    pc_redirect_s  = 1'b0;
    stall_inc_s    = 1'b0;
    flush_inc_s    = 1'b0;
    case (state_r)
      RUN, DWAIT: begin
        if (wb_halt) begin
          state_nxt_s = HALTED;
        end else if (dstall_s) begin
          state_nxt_s = DWAIT;
          stall_inc_s = 1'b1;
        end else begin
          state_nxt_s = RUN;
          if (taken_s) begin
            // squash the three younger stages; fetch restarts at the target
            pc_en_s        = 1'b1;
            pc_redirect_s  = 1'b1;
            if_id_flush_s  = 1'b1;
            id_ex_flush_s  = 1'b1;
            ex_mem_flush_s = 1'b1;
            mem_wb_en_s    = 1'b1;
            flush_inc_s    = 1'b1;
          end else if (loaduse_s) begin
            id_ex_flush_s = 1'b1;
            ex_mem_en_s   = 1'b1;
            mem_wb_en_s   = 1'b1;
            stall_inc_s   = 1'b1;
          end else if (!ihit) begin
            if_id_flush_s = 1'b1;
            id_ex_en_s    = 1'b1;
            ex_mem_en_s   = 1'b1;
            mem_wb_en_s   = 1'b1;
            stall_inc_s   = 1'b1;
          end else begin
            pc_en_s     = 1'b1;
            if_id_en_s  = 1'b1;
            id_ex_en_s  = 1'b1;
            ex_mem_en_s = 1'b1;
            mem_wb_en_s = 1'b1;
          end
        end
      end
      HALTED: begin
        state_nxt_s = HALTED;
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Sticky halt flag, set on the edge that enters HALTED
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      halt_r <= 1'b0;
    end else if (state_nxt_s == HALTED) begin
      halt_r <= 1'b1;
    end else begin
      halt_r <= halt_r;
    end
  end

  // Saturating stall-cycle counter; increment term is already 0 in HALTED
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cycles_r <= 32'd0;
    end else if (stall_inc_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
      stall_cycles_r <= stall_cycles_r + 32'd1;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  // Saturating taken-redirect counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      flush_count_r <= 32'd0;
    end else if (flush_inc_s && (flush_count_r != 32'hFFFF_FFFF)) begin
      flush_count_r <= flush_count_r + 32'd1;
    end else begin
      flush_count_r <= flush_count_r;
    end
  end

  // Reset masks the combinational controls so nothing loads during reset
  always_comb begin
    pc_en        = pc_en_s        & ~RST;
    if_id_en     = if_id_en_s     & ~RST;
    id_ex_en     = id_ex_en_s     & ~RST;
    ex_mem_en    = ex_mem_en_s    & ~RST;
    mem_wb_en    = mem_wb_en_s    & ~RST;
    if_id_flush  = if_id_flush_s  & ~RST;
    id_ex_flush  = id_ex_flush_s  & ~RST;
    ex_mem_flush = ex_mem_flush_s & ~RST;
    pc_redirect  = pc_redirect_s  & ~RST;
    halt         = halt_r;
    stall_cycles = stall_cycles_r;
    flush_count  = flush_count_r;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 CLK  in  1  rising-edge clock.
REQ-003 RST  in  1  asynchronous reset, active-high.
REQ-004 ihit  in  1  instruction fetch completes this cycle.
REQ-005 dhit  in  1  data access in MEM completes this cycle.
REQ-006 id_rs, id_rt  in  5 each (regbits_t)  source registers of the instruction in ID.
REQ-007 id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt.
REQ-008 ex_dREN  in  1  EX instruction is a load.
REQ-009 ex_regtbw  in  5  resolved destination register of the EX instruction.
REQ-010 mem_dREN, mem_dWEN  in  1 each  MEM instruction reads / writes data memory.
REQ-011 mem_pcsrc  in  3 (pcsrc_t)  PC source of the MEM instruction.
REQ-012 mem_zero  in  1  ALU zero flag of the MEM instruction.
REQ-013 wb_halt  in  1  halt instruction in WB.
REQ-014 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  PC / pipeline-register load enables.
REQ-015 if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load bubble; flush overrides en.
REQ-016 pc_redirect  out  1  PC loads the MEM branch/jump target instead of PC+4.
REQ-017 halt  out  1  registered, sticky halt.
REQ-018 stall_cycles, flush_count  out  32 each  performance counters.

Function
REQ-019 FSM states SHALL be RUN, DWAIT, HALTED; enable/flush/redirect outputs are combinational from state and inputs.
REQ-020 taken = mem_pcsrc in {PCSRC_REG, PCSRC_JAL} | (PCSRC_BEQ & mem_zero) | (PCSRC_BNE & ~mem_zero).
REQ-021 dpend = mem_dREN | mem_dWEN; dstall = dpend & ~dhit.
REQ-022 loaduse = ex_dREN & ex_regtbw!=0 & ((id_uses_rs & id_rs==ex_regtbw) | (id_uses_rt & id_rt==ex_regtbw)).
REQ-023 RUN priority, highest first: wb_halt > dstall > taken > loaduse > ~ihit > normal.
REQ-024 RUN, wb_halt: all enables 0, flushes 0; next state HALTED.
REQ-025 RUN, dstall: all enables 0, flushes 0, pc_redirect 0; next state DWAIT.
REQ-026 DWAIT: dstall again -> same outputs, stay. On dhit -> normal-advance outputs (REQ-030) with taken/loaduse/~ihit rules applied, next state RUN; wb_halt in DWAIT -> HALTED.
REQ-027 taken: pc_en=1, pc_redirect=1; flush if_id, id_ex, ex_mem; mem_wb_en=1; ihit is ignored.
REQ-028 loaduse: pc_en=0, if_id_en=0 (hold), id_ex_flush=1, ex_mem_en=1, mem_wb_en=1; this applies regardless of ihit.
REQ-029 ~ihit: pc_en=0, if_id_flush=1, id_ex_en, ex_mem_en, mem_wb_en all 1.
REQ-030 normal: all enables 1, flushes 0, pc_redirect 0.
REQ-031 HALTED: all enables, flushes, and pc_redirect 0; halt=1; state holds until RST.
REQ-032 halt SHALL rise on the clock edge that enters HALTED, i.e. one cycle after wb_halt is sampled.
REQ-033 stall_cycles SHALL increment on every clock edge not in HALTED where the cycle was dstall, loaduse (not taken), or ~ihit (not taken, not loaduse).
REQ-034 flush_count SHALL increment on each edge where taken was acted on (REQ-027).
REQ-035 Both counters SHALL saturate at 32'hFFFFFFFF and freeze in HALTED.

Reset
REQ-036 RST=1 SHALL immediately force state RUN, halt 0, and both counters 0, independent of CLK.
REQ-037 While RST=1, all enables, flushes, and pc_redirect SHALL be 0.
REQ-038 RST asserted mid-DWAIT or in HALTED SHALL return to RUN; the first post-reset cycle follows REQ-023.

Verification
REQ-039 Load-use: ex_dREN=1, ex_regtbw=5, id_rs=5, id_uses_rs=1, ihit=1 -> pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles 0->1.
REQ-040 Same as REQ-039 with ex_regtbw=0 -> normal advance; stall_cycles unchanged.
REQ-041 Data stall: mem_dREN=1, dhit=0 for 3 cycles, then dhit=1 -> all enables 0 for 3 cycles (DWAIT), then all enables 1 and state RUN; stall_cycles=3.
REQ-042 Branch: mem_pcsrc=PCSRC_BNE, mem_zero=0, ihit=0, loaduse true -> pc_redirect=1, three flushes 1, pc_en=1; flush_count=1, stall_cycles unchanged.
REQ-043 Halt: wb_halt=1 together with dstall -> next edge halt=1, all enables 0; counters frozen; RST pulse -> halt 0, counters 0.
REQ-044 Saturation: preload stall_cycles via 2^32-1 ~ihit cycles (or force) -> further ~ihit cycles keep the value at 32'hFFFFFFFF.
